// File: rtl/text_field_renderer_if.sv
// Pixel-in / glyph-out bus of the text field renderer.
//   master : pixel source side (drives pixel position, digits, edit controls;
//            receives font-ROM address, glyph column, colour, size, data-present)
//   slave  : renderer side
interface text_field_renderer_if #(
    parameter int unsigned N_FIELDS = 8,
    parameter int unsigned SELW     = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
);
    logic [9:0]            pixelx;
    logic [9:0]            pixely;
    logic [8*N_FIELDS-1:0] digits;
    logic                  edit_en;
    logic [SELW-1:0]       edit_sel;
    logic [10:0]           rom_addr;
    logic [2:0]            bit_col;
    logic [3:0]            color_addr;
    logic [1:0]            font_size;
    logic                  dp;

    modport master (
        output pixelx, pixely, digits, edit_en, edit_sel,
        input  rom_addr, bit_col, color_addr, font_size, dp
    );

    modport slave (
        input  pixelx, pixely, digits, edit_en, edit_sel,
        output rom_addr, bit_col, color_addr, font_size, dp
    );
endinterface

// File: rtl/text_field_renderer.sv
// VGA overlay drawing N_FIELDS two-digit BCD fields at fixed screen positions.
// Two-stage pipeline: stage 1 resolves field hit / glyph row / column / char,
// stage 2 applies edit colour and blink and registers the outputs.
// Ports:
//   clk        pixel clock
//   reset      synchronous, active-high
//   bus.pixelx / bus.pixely   current pixel
//   bus.digits                packed BCD, field i tens [8i+7:8i+4], units [8i+3:8i]
//   bus.edit_en / bus.edit_sel edit highlight control
//   bus.rom_addr {char, glyph_row}, bus.bit_col, bus.color_addr,
//   bus.font_size, bus.dp      registered outputs, 2 clk after the pixel
module text_field_renderer #(
    parameter int unsigned             N_FIELDS     = 8,
    parameter logic [10*N_FIELDS-1:0]  FIELD_X      = '0,
    parameter logic [10*N_FIELDS-1:0]  FIELD_Y      = '0,
    parameter int unsigned             SCALE        = 1,
    parameter logic [3:0]              COLOR_NORMAL = 4'd2,
    parameter logic [3:0]              COLOR_EDIT   = 4'd4,
    parameter int unsigned             BLINK_CYCLES = 12_500_000,
    parameter int unsigned             SELW         = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    text_field_renderer_if.slave  bus
);
    localparam int unsigned SHIFT   = (SCALE == 2) ? 1 : 0;
    localparam int unsigned FIELD_W = 16 * SCALE;
    localparam int unsigned GLYPH_H = 16 * SCALE;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [1:0]  FONT_CODE = (SCALE == 2) ? 2'd2 : 2'd1;

    // Frame snapshot of the digits
    logic [8*N_FIELDS-1:0] snap_q, snap_d;

    // Blink timer
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    // Stage 1
    logic            hit_q, hit_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic [3:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [6:0]      char_q, char_d;

    // Stage 2 (outputs)
    logic [10:0] rom_addr_q, rom_addr_d;
    logic [2:0]  bit_col_q, bit_col_d;
    logic [3:0]  color_q, color_d;
    logic [1:0]  font_size_q, font_size_d;
    logic        dp_q, dp_d;

    logic [10:0] px, py, fx, fy, dx, dy;
    logic [3:0]  digit;
    logic        sel, blank;

    // Latch new digits on the first pixel of the frame; that pixel already uses them
    always_comb begin
        snap_d = snap_q;
        if (bus.pixelx == 10'd0 && bus.pixely == 10'd0) begin
            snap_d = bus.digits;
        end
    end

    // Blink half-period timer, idle and visible while not editing
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (bus.edit_en) begin
            blink_on_d = blink_on_q;
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Stage 1: descending scan so the lowest-index field overwrites higher ones
    always_comb begin
        hit_d  = 1'b0;
        idx_d  = '0;
        row_d  = '0;
        col_d  = '0;
        char_d = '0;
        px     = {1'b0, bus.pixelx};
        py     = {1'b0, bus.pixely};
        fx     = '0;
        fy     = '0;
        dx     = '0;
        dy     = '0;
        digit  = '0;
        for (int i = int'(N_FIELDS) - 1; i >= 0; i--) begin
            fx = {1'b0, FIELD_X[10*i +: 10]};
            fy = {1'b0, FIELD_Y[10*i +: 10]};
            dx = px - fx;
            dy = py - fy;
            if (px >= fx && px <= fx + 11'(FIELD_W - 1) &&
                py >= fy && py <= fy + 11'(GLYPH_H - 1)) begin
                hit_d = 1'b1;
                idx_d = SELW'(i);
                row_d = 4'(dy >> SHIFT);
                // Units glyph starts 8*SCALE in; low column bits are unaffected by that offset
                col_d = 3'(dx >> SHIFT);
                digit = dx[3+SHIFT] ? snap_d[8*i +: 4] : snap_d[8*i+4 +: 4];
                char_d = (digit <= 4'd9) ? (7'h30 + 7'(digit)) : 7'h2D;
            end
        end
    end

    // Stage 2: colour, blink blanking (hides the whole pixel, not just the field)
    always_comb begin
        sel         = bus.edit_en && (bus.edit_sel == idx_q);
        blank       = sel && !blink_on_q;
        rom_addr_d  = '0;
        bit_col_d   = '0;
        color_d     = '0;
        dp_d        = 1'b0;
        font_size_d = FONT_CODE;
        if (hit_q && !blank) begin
            rom_addr_d = {char_q, row_q};
            bit_col_d  = col_q;
            color_d    = sel ? COLOR_EDIT : COLOR_NORMAL;
            dp_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q      <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            char_q      <= '0;
            rom_addr_q  <= '0;
            bit_col_q   <= '0;
            color_q     <= '0;
            font_size_q <= '0;
            dp_q        <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            hit_q       <= hit_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            char_q      <= char_d;
            rom_addr_q  <= rom_addr_d;
            bit_col_q   <= bit_col_d;
            color_q     <= color_d;
            font_size_q <= font_size_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.bit_col    = bit_col_q;
    assign bus.color_addr = color_q;
    assign bus.font_size  = font_size_q;
    assign bus.dp         = dp_q;
endmodule

// File: tb/tb_text_field_renderer.sv
// Directed bench for text_field_renderer: two instances (SCALE=1 and SCALE=2 with
// overlapping fields) share clock, reset and pixel position.
module tb_text_field_renderer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    text_field_renderer_if #(.N_FIELDS(2), .SELW(1)) ifa ();
    text_field_renderer_if #(.N_FIELDS(2), .SELW(1)) ifb ();

    text_field_renderer #(
        .N_FIELDS(2), .FIELD_X({10'd20, 10'd100}), .FIELD_Y({10'd40, 10'd40}),
        .SCALE(1), .COLOR_NORMAL(4'd2), .COLOR_EDIT(4'd4), .BLINK_CYCLES(4), .SELW(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

    text_field_renderer #(
        .N_FIELDS(2), .FIELD_X({10'd108, 10'd100}), .FIELD_Y({10'd40, 10'd40}),
        .SCALE(2), .COLOR_NORMAL(4'd2), .COLOR_EDIT(4'd4), .BLINK_CYCLES(4), .SELW(1)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    // {dp, rom_addr, bit_col, color_addr, font_size}
    logic [20:0] obs_a, obs_b;
    assign obs_a = {ifa.dp, ifa.rom_addr, ifa.bit_col, ifa.color_addr, ifa.font_size};
    assign obs_b = {ifb.dp, ifb.rom_addr, ifb.bit_col, ifb.color_addr, ifb.font_size};

    function automatic logic [20:0] ex(input logic d, input logic [10:0] r,
                                      input logic [2:0] c, input logic [3:0] co,
                                      input logic [1:0] fs);
        return {d, r, c, co, fs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        ifa.pixelx = 10'(x);
        ifa.pixely = 10'(y);
        ifb.pixelx = 10'(x);
        ifb.pixely = 10'(y);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_pix(500, 300);
        ifa.digits = 16'h0000; ifb.digits = 16'h0000;
        ifa.edit_en = 1'b0; ifa.edit_sel = 1'b0;
        ifb.edit_en = 1'b0; ifb.edit_sel = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (obs_a !== 21'd0) begin
            failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, 21'd0);
        end
        checks++;
        if (obs_b !== 21'd0) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, 21'd0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        logic [20:0] e;
        ifa.digits = 16'h0059;
        ifb.digits = 16'h3459;
        set_pix(0, 0);
        tick();
        // Streamed scan, one pixel per clock, result two clocks later
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) set_pix(98 + c, 40);
            tick();
            if (c >= 1) begin
                int x;
                x = 98 + c - 1;
                if (x >= 100 && x <= 107)      e = ex(1'b1, 11'h350, 3'(x - 100), 4'd2, 2'd1);
                else if (x >= 108 && x <= 115) e = ex(1'b1, 11'h390, 3'(x - 108), 4'd2, 2'd1);
                else                           e = ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd1);
                checks++;
                if (obs_a !== e) begin
                    failures++; $display("FAIL scan x=%0d got=%h exp=%h", x, obs_a, e);
                end
            end
        end
        set_pix(100, 55); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h35F, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL last_row got=%h exp=%h", obs_a, ex(1'b1, 11'h35F, 3'd0, 4'd2, 2'd1));
        end
        set_pix(100, 56); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd1)) begin
            failures++; $display("FAIL below_field got=%h exp=%h", obs_a, ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd1));
        end
        set_pix(20, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL field1 got=%h exp=%h", obs_a, ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1));
        end
    endtask

    task automatic test_scale2();
        int          xs[6] = '{103, 116, 135, 99, 139, 140};
        int          ys[6] = '{45, 40, 40, 40, 71, 40};
        logic [20:0] es[6];
        es[0] = ex(1'b1, 11'h352, 3'd1, 4'd2, 2'd2);
        es[1] = ex(1'b1, 11'h390, 3'd0, 4'd2, 2'd2);  // overlap: field 0 wins
        es[2] = ex(1'b1, 11'h340, 3'd5, 4'd2, 2'd2);
        es[3] = ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd2);
        es[4] = ex(1'b1, 11'h34F, 3'd7, 4'd2, 2'd2);
        es[5] = ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd2);
        for (int k = 0; k < 6; k++) begin
            set_pix(xs[k], ys[k]); tick(); tick();
            checks++;
            if (obs_b !== es[k]) begin
                failures++;
                $display("FAIL scale2 (%0d,%0d) got=%h exp=%h", xs[k], ys[k], obs_b, es[k]);
            end
        end
    endtask

    task automatic test_snapshot();
        ifa.digits = 16'h0012;
        set_pix(100, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h350, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL snap_hold got=%h exp=%h", obs_a, ex(1'b1, 11'h350, 3'd0, 4'd2, 2'd1));
        end
        set_pix(0, 0); tick();
        set_pix(100, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h310, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL snap_new_tens got=%h exp=%h", obs_a, ex(1'b1, 11'h310, 3'd0, 4'd2, 2'd1));
        end
        set_pix(108, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h320, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL snap_new_units got=%h exp=%h", obs_a, ex(1'b1, 11'h320, 3'd0, 4'd2, 2'd1));
        end
    endtask

    task automatic test_bad_bcd();
        ifa.digits = 16'h00A3;
        set_pix(0, 0); tick();
        set_pix(103, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h2D0, 3'd3, 4'd2, 2'd1)) begin
            failures++; $display("FAIL bad_bcd_tens got=%h exp=%h", obs_a, ex(1'b1, 11'h2D0, 3'd3, 4'd2, 2'd1));
        end
        set_pix(108, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h330, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL bad_bcd_units got=%h exp=%h", obs_a, ex(1'b1, 11'h330, 3'd0, 4'd2, 2'd1));
        end
    endtask

    task automatic test_blink();
        logic [20:0] e;
        set_pix(100, 40); tick(); tick();
        ifa.edit_en = 1'b1; ifa.edit_sel = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            tick();
            e = (((k / 4) % 2) == 0) ? ex(1'b1, 11'h2D0, 3'd0, 4'd4, 2'd1)
                                     : ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd1);
            checks++;
            if (obs_a !== e) begin
                failures++; $display("FAIL blink k=%0d got=%h exp=%h", k, obs_a, e);
            end
        end
        ifa.edit_en = 1'b0;
        tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h2D0, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL edit_drop got=%h exp=%h", obs_a, ex(1'b1, 11'h2D0, 3'd0, 4'd2, 2'd1));
        end
        ifa.edit_en = 1'b1;
        set_pix(20, 40); tick(); tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (obs_a !== ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1)) begin
                failures++;
                $display("FAIL unselected k=%0d got=%h exp=%h", k, obs_a, ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1));
            end
        end
        ifa.edit_en = 1'b0;
        tick();
    endtask

    task automatic test_overlap_blink();
        logic [20:0] e;
        set_pix(116, 40); tick(); tick();
        ifb.edit_en = 1'b1; ifb.edit_sel = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            e = (k < 4) ? ex(1'b1, 11'h390, 3'd0, 4'd4, 2'd2) : ex(1'b0, 11'h0, 3'd0, 4'd0, 2'd2);
            checks++;
            if (obs_b !== e) begin
                failures++; $display("FAIL overlap_blink k=%0d got=%h exp=%h", k, obs_b, e);
            end
        end
        ifb.edit_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ifa.digits = 16'h0077;
        set_pix(100, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h2D0, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL pre_reset got=%h exp=%h", obs_a, ex(1'b1, 11'h2D0, 3'd0, 4'd2, 2'd1));
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs_a !== 21'd0) begin
            failures++; $display("FAIL mid_reset_a got=%h exp=%h", obs_a, 21'd0);
        end
        checks++;
        if (obs_b !== 21'd0) begin
            failures++; $display("FAIL mid_reset_b got=%h exp=%h", obs_b, 21'd0);
        end
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL post_reset_a got=%h exp=%h", obs_a, ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd1));
        end
        checks++;
        if (obs_b !== ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd2)) begin
            failures++; $display("FAIL post_reset_b got=%h exp=%h", obs_b, ex(1'b1, 11'h300, 3'd0, 4'd2, 2'd2));
        end
        set_pix(0, 0); tick();
        set_pix(100, 40); tick(); tick();
        checks++;
        if (obs_a !== ex(1'b1, 11'h370, 3'd0, 4'd2, 2'd1)) begin
            failures++; $display("FAIL post_frame got=%h exp=%h", obs_a, ex(1'b1, 11'h370, 3'd0, 4'd2, 2'd1));
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_scale2();
        test_snapshot();
        test_bad_bcd();
        test_blink();
        test_overlap_blink();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
